dir_step_ctrl: RTL and testbench

DIR_STEP_CTRL -- requirements
Module: dir_step_ctrl

---
 rtl/dir_step_pkg.sv | 16 +
 rtl/btn_debounce.sv | 80 ++++++++
 rtl/dir_step_ctrl.sv | 72 +++++++
 tb/tb_dir_step_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dir_step_pkg.sv
// Shared types and defaults for the direction/step controller.
// Debounce FSM encoding, counter width and default timing parameters.
package dir_step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE_LOW   = 2'd0,
    ST_CHECK_HIGH = 2'd1,
    ST_IDLE_HIGH  = 2'd2,
    ST_CHECK_LOW  = 2'd3
  } db_state_t;

  localparam int CNT_W        = 16;
  localparam int DB_LIMIT_DEF = 16;
  localparam int TICK_DIV_DEF = 8;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, level debounce FSM with a
// stability counter, and a one-cycle pulse on each accepted press.
module btn_debounce
  import dir_step_pkg::*;
#(
  parameter int DB_LIMIT = DB_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(DB_LIMIT - 1);

  logic             r_sync1, r_sync2;
  db_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; with blocking, r_sync2 would copy the new r_sync1 and the
  // synchronizer would collapse into a single flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= ST_IDLE_LOW;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every output of this block is assigned a default first, so paths
  // that leave a signal untouched cannot infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_press     = 1'b0;
    case (r_state)
      ST_IDLE_LOW: begin
        if (r_sync2) begin
          w_state_nxt = ST_CHECK_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      ST_CHECK_HIGH: begin
        if (!r_sync2) begin
          w_state_nxt = ST_IDLE_LOW;
        end else if (r_cnt == LIMIT_M1) begin
          w_state_nxt = ST_IDLE_HIGH;
          o_press     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_IDLE_HIGH: begin
        if (!r_sync2) begin
          w_state_nxt = ST_CHECK_LOW;
          w_cnt_nxt   = '0;
        end
      end
      ST_CHECK_LOW: begin
        // Release acceptance only returns to IDLE_LOW; it raises no event.
        if (r_sync2) begin
          w_state_nxt = ST_IDLE_HIGH;
        end else if (r_cnt == LIMIT_M1) begin
          w_state_nxt = ST_IDLE_LOW;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE_LOW;
    endcase
  end

endmodule

// File: rtl/dir_step_ctrl.sv
// Direction toggle and step-rate generator for an up/down counter.
// Define DIR_STEP_PAUSE_EN to add a debounced btn_pause run/stop control.
module dir_step_ctrl
  import dir_step_pkg::*;
#(
  parameter int DB_LIMIT = DB_LIMIT_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_dir,
`ifdef DIR_STEP_PAUSE_EN
  input  logic btn_pause,
`endif
  output logic up_down,
  output logic step,
  output logic dir_pulse
);

  localparam logic [CNT_W-1:0] TICK_M1 = CNT_W'(TICK_DIV - 1);

  logic             w_dir_press;
  logic             w_run;
  logic             w_tick;
  logic [CNT_W-1:0] r_presc;

  btn_debounce #(.DB_LIMIT(DB_LIMIT)) u_dir_db (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (btn_dir),
    .o_press (w_dir_press)
  );

`ifdef DIR_STEP_PAUSE_EN
  logic w_pause_press;
  logic r_run;

  btn_debounce #(.DB_LIMIT(DB_LIMIT)) u_pause_db (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (btn_pause),
    .o_press (w_pause_press)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              r_run <= 1'b1;
    else if (w_pause_press) r_run <= ~r_run;
  end

  assign w_run = r_run;
`else
  assign w_run = 1'b1;
`endif

  // While stopped the prescaler holds its count so the period resumes mid-way.
  assign w_tick = w_run && (r_presc == TICK_M1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc   <= '0;
      step      <= 1'b0;
      up_down   <= 1'b1;
      dir_pulse <= 1'b0;
    end else begin
      if (w_run) r_presc <= (r_presc == TICK_M1) ? '0 : r_presc + CNT_W'(1);
      step      <= w_tick;
      dir_pulse <= w_dir_press;
      if (w_dir_press) up_down <= ~up_down;
    end
  end

endmodule

// File: tb/tb_dir_step_ctrl.sv
// Directed self-checking bench for dir_step_ctrl with DB_LIMIT=4, TICK_DIV=8.
// The btn_pause sequence is compiled only when DIR_STEP_PAUSE_EN is defined.
module tb_dir_step_ctrl;

  localparam int DB = 4;
  localparam int TD = 8;

  logic clk = 1'b0;
  logic reset;
  logic btn_dir;
`ifdef DIR_STEP_PAUSE_EN
  logic btn_pause;
`endif
  logic up_down;
  logic step;
  logic dir_pulse;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  dir_step_ctrl #(.DB_LIMIT(DB), .TICK_DIV(TD)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_dir   (btn_dir),
`ifdef DIR_STEP_PAUSE_EN
    .btn_pause (btn_pause),
`endif
    .up_down   (up_down),
    .step      (step),
    .dir_pulse (dir_pulse)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 ns after it, inputs change there.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s@%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // Step is expected on every multiple of TD edges since reset release.
  task automatic check_cycle(input logic exp_ud, input logic exp_dp);
    check("step", step, (cyc > 0) && (cyc % TD == 0));
    check("up_down", up_down, exp_ud);
    check("dir_pulse", dir_pulse, exp_dp);
  endtask

  initial begin
    reset   = 1'b1;
    btn_dir = 1'b0;
`ifdef DIR_STEP_PAUSE_EN
    btn_pause = 1'b0;
`endif
    #1;
    check("rst_up_down", up_down, 1'b1);
    check("rst_step", step, 1'b0);
    check("rst_dir_pulse", dir_pulse, 1'b0);
    repeat (3) tick();
    check("rst_hold_up_down", up_down, 1'b1);
    check("rst_hold_step", step, 1'b0);
    reset = 1'b0;
    cyc   = 0;

    // Free-running steps at 8, 16, 24; direction stays up.
    for (int i = 1; i <= 24; i++) begin
      tick();
      check_cycle(1'b1, 1'b0);
    end

    // Stable press: first sampled at edge +1, toggle 6 edges later.
    btn_dir = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_cycle((i >= 7) ? 1'b0 : 1'b1, i == 7);
    end
    btn_dir = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_cycle(1'b0, 1'b0);
    end

    // Bounces of 1..3 cycles separated by 4-cycle gaps: no toggle.
    for (int len = 1; len <= 3; len++) begin
      btn_dir = 1'b1;
      for (int i = 0; i < len; i++) begin
        tick();
        check_cycle(1'b0, 1'b0);
      end
      btn_dir = 1'b0;
      for (int i = 0; i < 4; i++) begin
        tick();
        check_cycle(1'b0, 1'b0);
      end
    end

    // A 10-cycle press then yields exactly one toggle.
    btn_dir = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_cycle((i >= 7) ? 1'b1 : 1'b0, i == 7);
    end
    btn_dir = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_cycle(1'b1, 1'b0);
    end

    // Align the press so the toggle edge is also a step edge.
    while (cyc % TD != 1) begin
      tick();
      check_cycle(1'b1, 1'b0);
    end
    btn_dir = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_cycle((i == 7) ? 1'b0 : 1'b1, i == 7);
    end
    check("coincide_step", step, 1'b1);
    check("coincide_up_down", up_down, 1'b0);
    // Holding the button must not auto-repeat.
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_cycle(1'b0, 1'b0);
    end
    btn_dir = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_cycle(1'b0, 1'b0);
    end

    // Reset two edges into CHECK_HIGH, button kept high throughout.
    btn_dir = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_cycle(1'b0, 1'b0);
    end
    reset = 1'b1;
    #1;
    check("midrst_up_down", up_down, 1'b1);
    check("midrst_step", step, 1'b0);
    check("midrst_dir_pulse", dir_pulse, 1'b0);
    for (int i = 1; i <= 2; i++) begin
      tick();
      check("inrst_up_down", up_down, 1'b1);
      check("inrst_step", step, 1'b0);
      check("inrst_dir_pulse", dir_pulse, 1'b0);
    end
    reset = 1'b0;
    cyc   = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check_cycle((i >= 7) ? 1'b0 : 1'b1, i == 7);
    end
    btn_dir = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_cycle(1'b0, 1'b0);
    end

`ifdef DIR_STEP_PAUSE_EN
    // Pause press at cyc%8==2: run clears on edge +7 with the prescaler at 1.
    while (cyc % TD != 2) begin
      tick();
      check_cycle(1'b0, 1'b0);
    end
    btn_pause = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_cycle(1'b0, 1'b0);
    end
    for (int i = 8; i <= 20; i++) begin
      if (i == 11) btn_pause = 1'b0;
      tick();
      check("paused_step", step, 1'b0);
      check("paused_up_down", up_down, 1'b0);
    end
    // Resume: run sets on edge +7, prescaler continues 1..7, step on +14, +22.
    btn_pause = 1'b1;
    for (int j = 1; j <= 24; j++) begin
      if (j == 11) btn_pause = 1'b0;
      tick();
      check("resume_step", step, (j == 14) || (j == 22));
      check("resume_up_down", up_down, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
